// File: rtl/axi_ram.sv
// Single-port AXI4 slave RAM of 64-bit words. Handles one transaction at a time.
// AW and AR contend round-robin, and every burst is INCR with 8-byte beats.
module axi_ram #(
    parameter int unsigned depth = 1024,
    parameter logic [63:0] base  = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [7:0]  s_axi_awid,
    input  logic [63:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,

    input  logic [63:0] s_axi_wdata,
    input  logic [7:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,

    output logic [7:0]  s_axi_bid,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,

    input  logic [7:0]  s_axi_arid,
    input  logic [63:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,

    output logic [7:0]  s_axi_rid,
    output logic [63:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);

    localparam int          AW   = $clog2(depth);
    localparam logic [63:0] SPAN = 64'(depth) << 3;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

    // Unsigned compare also rejects addresses below base, since the subtraction wraps.
    function automatic logic in_range(input logic [63:0] addr);
        return (addr - base) < SPAN;
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [63:0] addr, input logic [7:0] beat);
        return AW'((addr - base) >> 3) + AW'(beat);
    endfunction

    logic [63:0] mem [depth];

    state_t      state_q, state_d;
    logic        grant_wr_q, grant_wr_d;
    logic [7:0]  id_q, id_d;
    logic [63:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  beat_q, beat_d;
    logic        in_range_q, in_range_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [7:0]  bid_q, bid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        rvalid_q, rvalid_d;
    logic [7:0]  rid_q, rid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;
    logic [63:0] rdata_q;

    logic          awready_c, arready_c;
    logic          grant_aw, grant_ar;
    logic [7:0]    beat_nxt;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic          rd_en;
    logic          rd_ok;
    logic [AW-1:0] rd_idx;

    logic unused_wlast;
    assign unused_wlast = s_axi_wlast;

    always_comb begin
        state_d    = state_q;
        grant_wr_d = grant_wr_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        in_range_d = in_range_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rid_d      = rid_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        awready_c  = 1'b0;
        arready_c  = 1'b0;
        grant_aw   = 1'b0;
        grant_ar   = 1'b0;
        beat_nxt   = beat_q + 8'd1;
        wr_en      = 1'b0;
        wr_idx     = word_idx(addr_q, beat_q);
        rd_en      = 1'b0;
        rd_ok      = in_range_q;
        rd_idx     = word_idx(addr_q, beat_nxt);

        unique case (state_q)
            IDLE: begin
                grant_aw  = s_axi_awvalid && (!s_axi_arvalid || grant_wr_q);
                grant_ar  = s_axi_arvalid && !grant_aw;
                awready_c = grant_aw && !rst;
                arready_c = grant_ar && !rst;
                if (awready_c) begin
                    id_d       = s_axi_awid;
                    addr_d     = s_axi_awaddr;
                    len_d      = s_axi_awlen;
                    beat_d     = 8'd0;
                    in_range_d = in_range(s_axi_awaddr);
                    wready_d   = 1'b1;
                    grant_wr_d = 1'b0;
                    state_d    = WRITE;
                end else if (arready_c) begin
                    id_d       = s_axi_arid;
                    addr_d     = s_axi_araddr;
                    len_d      = s_axi_arlen;
                    beat_d     = 8'd0;
                    in_range_d = in_range(s_axi_araddr);
                    grant_wr_d = 1'b1;
                    // Beat 0 is fetched on the handshake edge so rvalid rises the next cycle.
                    rd_en      = 1'b1;
                    rd_ok      = in_range(s_axi_araddr);
                    rd_idx     = word_idx(s_axi_araddr, 8'd0);
                    rvalid_d   = 1'b1;
                    rid_d      = s_axi_arid;
                    rresp_d    = rd_ok ? RESP_OKAY : RESP_SLVERR;
                    rlast_d    = (s_axi_arlen == 8'd0);
                    state_d    = READ;
                end
            end
            WRITE: begin
                if (s_axi_wvalid && wready_q) begin
                    wr_en  = in_range_q && !rst;
                    beat_d = beat_nxt;
                    if (beat_q == len_q) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bid_d    = id_q;
                        bresp_d  = in_range_q ? RESP_OKAY : RESP_SLVERR;
                        state_d  = WRESP;
                    end
                end
            end
            WRESP: begin
                if (s_axi_bready) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            READ: begin
                // Next beat is fetched on the accepting edge, keeping back-to-back beats bubble-free.
                if (s_axi_rready && rvalid_q) begin
                    if (rlast_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        beat_d  = beat_nxt;
                        rd_en   = 1'b1;
                        rlast_d = (beat_nxt == len_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_wr_q <= 1'b1;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= 8'd0;
            bresp_q    <= 2'b00;
            rvalid_q   <= 1'b0;
            rid_q      <= 8'd0;
            rresp_q    <= 2'b00;
            rlast_q    <= 1'b0;
            rdata_q    <= 64'd0;
        end else begin
            state_q    <= state_d;
            grant_wr_q <= grant_wr_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bid_q      <= bid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rid_q      <= rid_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
            if (rd_en) begin
                rdata_q <= rd_ok ? mem[rd_idx] : 64'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        id_q       <= id_d;
        addr_q     <= addr_d;
        len_q      <= len_d;
        beat_q     <= beat_d;
        in_range_q <= in_range_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (s_axi_wstrb[i]) begin
                    mem[wr_idx][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
                end
            end
        end
    end

    assign s_axi_awready = awready_c;
    assign s_axi_arready = arready_c;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_ram.sv
// Scoreboard bench for axi_ram: drivers queue expected B/R responses, a negedge monitor checks them.
module tb_axi_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axi_awid;
    logic [63:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic        s_axi_awvalid, s_axi_awready;
    logic [63:0] s_axi_wdata;
    logic [7:0]  s_axi_wstrb;
    logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [7:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic [7:0]  s_axi_arid;
    logic [63:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic        s_axi_arvalid, s_axi_arready;
    logic [7:0]  s_axi_rid;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

    always #5 clk = ~clk;

    axi_ram #(.depth(1024), .base(64'h8000_0000)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    typedef struct packed { logic [7:0] id; logic [1:0] resp; } bexp_t;
    typedef struct packed { logic [7:0] id; logic [63:0] data; logic [1:0] resp; logic last; } rexp_t;

    int          total = 0;
    int          bad   = 0;
    bexp_t       exp_b[$];
    rexp_t       exp_r[$];
    logic [7:0]  grant_log[$];
    logic [63:0] wbuf[8];
    logic [63:0] ebuf[8];
    logic [63:0] ebuf2[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no handshake expected one within bound", name);
    endtask

    // Monitor: scoreboard pops, grant order log and R hold-stability.
    initial begin
        logic  stall_prev;
        rexp_t held, e;
        bexp_t b;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("r_hold_valid", 64'(s_axi_rvalid), 64'd1);
                    check("r_hold_fields", {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}, held);
                end
                if (s_axi_awvalid && s_axi_awready) grant_log.push_back(8'h57);
                if (s_axi_arvalid && s_axi_arready) grant_log.push_back(8'h52);
                if (s_axi_bvalid && s_axi_bready) begin
                    if (exp_b.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_b: got bid %h expected no response", s_axi_bid);
                    end else begin
                        b = exp_b.pop_front();
                        check("b_id", 64'(s_axi_bid), 64'(b.id));
                        check("b_resp", 64'(s_axi_bresp), 64'(b.resp));
                    end
                end
                if (s_axi_rvalid && s_axi_rready) begin
                    if (exp_r.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_r: got rid %h expected no beat", s_axi_rid);
                    end else begin
                        e = exp_r.pop_front();
                        check("r_id", 64'(s_axi_rid), 64'(e.id));
                        check("r_data", s_axi_rdata, e.data);
                        check("r_resp", 64'(s_axi_rresp), 64'(e.resp));
                        check("r_last", 64'(s_axi_rlast), 64'(e.last));
                    end
                end
                stall_prev = s_axi_rvalid && !s_axi_rready;
                held = {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast};
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog");
    end

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic aw_req(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len);
        int n;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_awready && n < 200);
        if (!s_axi_awready) timeout("aw_handshake");
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic ar_req(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len);
        int n;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_arready && n < 200);
        if (!s_axi_arready) timeout("ar_handshake");
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_wready && n < 200);
        if (!s_axi_wready) timeout("w_handshake");
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    endtask

    task automatic wait_b_done();
        int n;
        n = 0;
        while (exp_b.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (exp_b.size() != 0) begin timeout("b_response"); exp_b.delete(); end
        @(posedge clk); #1;
    endtask

    task automatic wait_r_done();
        int n;
        n = 0;
        while (exp_r.size() != 0 && n < 400) begin @(negedge clk); n++; end
        if (exp_r.size() != 0) begin timeout("r_response"); exp_r.delete(); end
        @(posedge clk); #1;
    endtask

    task automatic write_burst(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                               input logic [7:0] strb, input logic [1:0] resp);
        exp_b.push_back({id, resp});
        aw_req(id, addr, len);
        for (int i = 0; i <= int'(len); i++) w_beat(wbuf[i], strb, i == int'(len));
        wait_b_done();
    endtask

    task automatic push_r(input logic [7:0] id, input logic [7:0] len, input logic [1:0] resp,
                          input logic use_alt);
        for (int i = 0; i <= int'(len); i++)
            exp_r.push_back({id, (resp == 2'b00) ? (use_alt ? ebuf2[i] : ebuf[i]) : 64'd0,
                             resp, (i == int'(len))});
    endtask

    task automatic read_burst(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                              input logic [1:0] resp, input logic use_alt);
        push_r(id, len, resp, use_alt);
        ar_req(id, addr, len);
        wait_r_done();
    endtask

    initial begin
        s_axi_awid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awvalid = 0;
        s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0; s_axi_wvalid = 0;
        s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arvalid = 0;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;

        // Reset: outputs cleared, no AW grant while rst is high.
        rst = 1'b1;
        s_axi_awvalid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 64'(s_axi_awready), 64'd0);
        s_axi_awvalid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_wready", 64'(s_axi_wready), 64'd0);
        check("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
        check("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
        check("rst_rlast", 64'(s_axi_rlast), 64'd0);
        check("rst_rdata", s_axi_rdata, 64'd0);
        check("rst_bid_rid", {s_axi_bid, s_axi_rid, s_axi_bresp, s_axi_rresp}, 64'd0);
        @(posedge clk); #1;

        // Single-beat write then read back.
        wbuf[0] = 64'h1122334455667788;
        write_burst(8'h11, 64'h8000_0010, 8'd0, 8'hFF, 2'b00);
        ebuf[0] = 64'h1122334455667788;
        read_burst(8'h22, 64'h8000_0010, 8'd0, 2'b00, 1'b0);

        // Partial strobe merge.
        wbuf[0] = 64'h0102030405060708;
        write_burst(8'h03, 64'h8000_0018, 8'd0, 8'hFF, 2'b00);
        wbuf[0] = 64'hAAAAAAAAAAAAAAAA;
        write_burst(8'h04, 64'h8000_0018, 8'd0, 8'h0F, 2'b00);
        ebuf[0] = 64'h01020304AAAAAAAA;
        read_burst(8'h05, 64'h8000_0018, 8'd0, 2'b00, 1'b0);

        // 4-beat burst: latency and back-to-back beats, then held beats under rready toggling.
        for (int i = 0; i < 4; i++) begin wbuf[i] = 64'hD000 + 64'(i); ebuf[i] = 64'hD000 + 64'(i); end
        write_burst(8'h06, 64'h8000_0000, 8'd3, 8'hFF, 2'b00);
        push_r(8'h07, 8'd3, 2'b00, 1'b0);
        ar_req(8'h07, 64'h8000_0000, 8'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("burst_rvalid_beat", 64'(s_axi_rvalid), 64'd1);
        end
        @(negedge clk);
        check("burst_rvalid_after", 64'(s_axi_rvalid), 64'd0);
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
        push_r(8'h08, 8'd3, 2'b00, 1'b0);
        ar_req(8'h08, 64'h8000_0000, 8'd3);
        begin
            int n;
            n = 0;
            while (exp_r.size() != 0 && n < 100) begin
                @(posedge clk); #1 s_axi_rready = ~s_axi_rready; n++;
            end
            if (exp_r.size() != 0) begin timeout("toggle_read"); exp_r.delete(); end
        end
        s_axi_rready = 1'b1;
        @(posedge clk); #1;

        // Contending AW/AR: grant order must be W, R, W, R from reset.
        reset_dut();
        grant_log.delete();
        fork
            begin
                wbuf[0] = 64'hCAFE0001;
                write_burst(8'h30, 64'h8000_0040, 8'd0, 8'hFF, 2'b00);
                wbuf[0] = 64'hCAFE0002;
                write_burst(8'h31, 64'h8000_0048, 8'd0, 8'hFF, 2'b00);
            end
            begin
                ebuf[0] = 64'hD000;
                read_burst(8'h40, 64'h8000_0000, 8'd0, 2'b00, 1'b0);
                ebuf[0] = 64'hD001;
                read_burst(8'h41, 64'h8000_0008, 8'd0, 2'b00, 1'b0);
            end
        join
        check("grant_count", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() == 4) begin
            check("grant_0", 64'(grant_log[0]), 64'h57);
            check("grant_1", 64'(grant_log[1]), 64'h52);
            check("grant_2", 64'(grant_log[2]), 64'h57);
            check("grant_3", 64'(grant_log[3]), 64'h52);
        end
        ebuf[0] = 64'hCAFE0001; ebuf[1] = 64'hCAFE0002;
        read_burst(8'h42, 64'h8000_0040, 8'd1, 2'b00, 1'b0);

        // Out-of-range write and reads.
        wbuf[0] = 64'h5555AAAA5555AAAA;
        write_burst(8'h50, 64'h8000_1FF8, 8'd0, 8'hFF, 2'b00);
        wbuf[0] = 64'hFFFFFFFFFFFFFFFF; wbuf[1] = 64'hFFFFFFFFFFFFFFFF;
        write_burst(8'h51, 64'h7FFF_FFF8, 8'd1, 8'hFF, 2'b10);
        ebuf[0] = 64'h5555AAAA5555AAAA;
        read_burst(8'h52, 64'h8000_1FF8, 8'd0, 2'b00, 1'b0);
        ebuf[0] = 64'hD000;
        read_burst(8'h53, 64'h8000_0000, 8'd0, 2'b00, 1'b0);
        read_burst(8'h54, 64'h8000_2000, 8'd1, 2'b10, 1'b0);

        // Reset during beat 2 of an 8-beat write.
        for (int i = 0; i < 8; i++) wbuf[i] = 64'h7000 + 64'(i);
        write_burst(8'h60, 64'h8000_0100, 8'd7, 8'hFF, 2'b00);
        aw_req(8'h61, 64'h8000_0100, 8'd7);
        w_beat(64'hE000, 8'hFF, 1'b0);
        w_beat(64'hE001, 8'hFF, 1'b0);
        s_axi_wdata = 64'hE002; s_axi_wstrb = 8'hFF; s_axi_wvalid = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; s_axi_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_bvalid", 64'(s_axi_bvalid), 64'd0);
            check("abort_wready", 64'(s_axi_wready), 64'd0);
        end
        @(posedge clk); #1;
        ebuf2[0] = 64'hE000; ebuf2[1] = 64'hE001;
        for (int i = 2; i < 8; i++) ebuf2[i] = 64'h7000 + 64'(i);
        read_burst(8'h62, 64'h8000_0100, 8'd7, 2'b00, 1'b1);

        repeat (3) @(posedge clk);
        check("leftover_b", 64'(exp_b.size()), 64'd0);
        check("leftover_r", 64'(exp_r.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
